// File: rtl/jstk_spi_responder_if.sv
// SPI link between the rocker master and the joystick responder.
// The master drives SS/SCLK/MOSI and the responder drives MISO. There is no valid/ready handshake:
// SCLK edges qualify data only while SS is low, and MOSI/MISO are shifted MSB first in SPI mode 0.
interface jstk_spi_responder_if;
  logic SS;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (
    output SS,
    output SCLK,
    output MOSI,
    input  MISO
  );

  modport slave (
    input  SS,
    input  SCLK,
    input  MOSI,
    output MISO
  );
endinterface

// File: rtl/jstk_spi_responder.sv
// Joystick emulator on the rocker SPI link: answers each 5-byte master frame with an
// X/Y/button snapshot taken at SS fall and captures the master's command byte.
module jstk_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  jstk_spi_responder_if.slave   spi,
  input  logic [9:0]            x_pos,
  input  logic [9:0]            y_pos,
  input  logic [2:0]            buttons,
  output logic [1:0]            led,
  output logic [7:0]            cmd_byte,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    OVERRUN = 2'd2
  } state_t;

  localparam logic [5:0] FRAME_BITS = 6'd40;

  state_t      state;
  logic [5:0]  bit_cnt;
  logic [39:0] tx_shift;
  logic [7:0]  rx_shift;
  logic [7:0]  pending;
  logic        miso_q;

  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   ss_d;
  logic                   sclk_d;

  logic ss_s;
  logic sclk_s;
  logic mosi_s;
  logic ss_fall;
  logic ss_rise;
  logic sclk_rise;
  logic sclk_fall;
  logic [39:0] snapshot;

  // Synchronizers run through reset so a master still holding SS low after a
  // mid-frame reset does not look like a fresh SS fall.
  always_ff @(posedge clk) begin
    ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi.SS};
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
    ss_d      <= ss_s;
    sclk_d    <= sclk_s;
  end

  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_fall   = ss_d & ~ss_s;
  assign ss_rise   = ~ss_d & ss_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;

  assign snapshot = {x_pos[7:0], 6'b0, x_pos[9:8],
                     y_pos[7:0], 6'b0, y_pos[9:8],
                     5'b0, buttons};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      pending    <= '0;
      miso_q     <= 1'b0;
      led        <= 2'b00;
      cmd_byte   <= 8'h00;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (ss_rise && (state != IDLE)) begin
        state  <= IDLE;
        miso_q <= 1'b0;
        if (bit_cnt == FRAME_BITS) begin
          cmd_byte   <= pending;
          frame_done <= 1'b1;
          if (pending[7]) begin
            led <= pending[1:0];
          end
        end else begin
          frame_err <= 1'b1;
        end
      end else begin
        unique case (state)
          IDLE: begin
            miso_q <= 1'b0;
            // The load wins over any SCLK edge seen in the same cycle.
            if (ss_fall) begin
              tx_shift <= snapshot;
              miso_q   <= snapshot[39];
              bit_cnt  <= '0;
              state    <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (sclk_rise) begin
              rx_shift <= {rx_shift[6:0], mosi_s};
              bit_cnt  <= bit_cnt + 6'd1;
              if (bit_cnt == 6'd7) begin
                pending <= {rx_shift[6:0], mosi_s};
              end
              if (bit_cnt == FRAME_BITS - 6'd1) begin
                state  <= OVERRUN;
                miso_q <= 1'b0;
              end
            end else if (sclk_fall) begin
              tx_shift <= {tx_shift[38:0], 1'b0};
              miso_q   <= tx_shift[38];
            end
          end
          OVERRUN: begin
            miso_q <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            miso_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign spi.MISO  = miso_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Bench for jstk_spi_responder: a model master drives SPI frames; expected MISO bytes,
// command/LED state and pulse counts come from a frame-level model of the joystick.
module tb_jstk_spi_responder;

  localparam int HALF = 8;

  logic       clk;
  logic       rst;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [2:0] buttons;
  logic [1:0] led;
  logic [7:0] cmd_byte;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] dbg_state;

  jstk_spi_responder_if spi_if ();

  jstk_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi        (spi_if),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .buttons    (buttons),
    .led        (led),
    .cmd_byte   (cmd_byte),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic [7:0] exp_q[$];
  logic [1:0] exp_led = 2'b00;
  logic [7:0] exp_cmd = 8'h00;
  logic [7:0] rx_bytes [6];
  int done_cnt  = 0;
  int err_cnt   = 0;
  int since_evt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: pulse counting plus steady-state output checks
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
    if (frame_done && frame_err) check("both_pulses", 1, 0);
    since_evt++;
    if (!rst && since_evt > 6) begin
      check("led_steady", {30'b0, led}, {30'b0, exp_led});
      check("cmd_steady", {24'b0, cmd_byte}, {24'b0, exp_cmd});
      if (spi_if.SS) begin
        check("idle_miso", {31'b0, spi_if.MISO}, 32'd0);
        check("idle_state", {30'b0, dbg_state}, 32'd0);
      end
    end
  end

  // driver: one master frame of nbits SCLK pulses
  task automatic run_frame(input int nbits, input logic [7:0] cmd, input int rst_at, input int xchg_at);
    logic [7:0] rx;
    logic [7:0] eb;
    logic       exp_bit;
    int d0, e0;
    bit did_rst;
    d0 = done_cnt;
    e0 = err_cnt;
    did_rst = 0;
    rx = 8'h00;
    exp_q.delete();
    exp_q.push_back(x_pos[7:0]);
    exp_q.push_back({6'b0, x_pos[9:8]});
    exp_q.push_back(y_pos[7:0]);
    exp_q.push_back({6'b0, y_pos[9:8]});
    exp_q.push_back({5'b0, buttons});
    for (int k = 0; k < 3; k++) exp_q.push_back(8'h00);
    for (int k = 0; k < 6; k++) rx_bytes[k] = 8'h00;
    spi_if.SS   = 1'b0;
    spi_if.SCLK = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_if.MOSI = (i < 8) ? cmd[7-i] : 1'($urandom_range(0, 1));
      if (i == rst_at) begin
        rst = 1'b1;
        exp_led = 2'b00;
        exp_cmd = 8'h00;
        since_evt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        since_evt = 0;
        did_rst = 1;
        repeat (HALF - 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      eb = exp_q[i/8];
      exp_bit = did_rst ? 1'b0 : eb[7 - (i % 8)];
      check("miso_bit", {31'b0, spi_if.MISO}, {31'b0, exp_bit});
      rx = {rx[6:0], spi_if.MISO};
      if ((i % 8) == 7 && (i / 8) < 6) rx_bytes[i/8] = rx;
      spi_if.SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_if.SCLK = 1'b0;
      if (i == xchg_at) x_pos = 10'($urandom_range(0, 1023));
    end
    repeat (HALF) @(negedge clk);
    spi_if.SS = 1'b1;
    since_evt = 0;
    if (!did_rst && nbits >= 40) begin
      exp_cmd = cmd;
      if (cmd[7]) exp_led = cmd[1:0];
    end
    repeat (14) @(negedge clk);
    check("done_pulses", done_cnt - d0, (!did_rst && nbits >= 40) ? 1 : 0);
    check("err_pulses", err_cnt - e0, (!did_rst && nbits < 40) ? 1 : 0);
  endtask

  logic [7:0] pin_a [5];
  logic [7:0] pin_b [5];

  initial begin
    pin_a = '{8'hA5, 8'h02, 8'h3C, 8'h01, 8'h05};
    pin_b = '{8'h00, 8'h00, 8'hFF, 8'h03, 8'h00};
    rst = 1'b1;
    spi_if.SS = 1'b1;
    spi_if.SCLK = 1'b0;
    spi_if.MOSI = 1'b0;
    x_pos = '0;
    y_pos = '0;
    buttons = '0;
    repeat (4) @(negedge clk);
    check("rst_miso", {31'b0, spi_if.MISO}, 32'd0);
    check("rst_led", {30'b0, led}, 32'd0);
    check("rst_cmd", {24'b0, cmd_byte}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    rst = 1'b0;
    since_evt = 0;
    repeat (3) @(negedge clk);
    check("rst_done", {31'b0, frame_done}, 32'd0);
    check("rst_err", {31'b0, frame_err}, 32'd0);
    repeat (6) @(negedge clk);

    // full frame with LED command
    x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
    run_frame(40, 8'h83, -1, -1);
    for (int k = 0; k < 5; k++) check("pin_frame_a", {24'b0, rx_bytes[k]}, {24'b0, pin_a[k]});
    check("pin_led_a", {30'b0, led}, 32'd3);
    check("pin_cmd_a", {24'b0, cmd_byte}, 32'h83);

    // command without bit 7 leaves LEDs alone
    run_frame(40, 8'h02, -1, -1);
    check("pin_cmd_b", {24'b0, cmd_byte}, 32'h02);
    check("pin_led_b", {30'b0, led}, 32'd3);

    // abort after 17 bits, then boundary positions
    run_frame(17, 8'h81, -1, -1);
    check("pin_cmd_abort", {24'b0, cmd_byte}, 32'h02);
    x_pos = 10'd0; y_pos = 10'd1023; buttons = 3'b000;
    run_frame(40, 8'h00, -1, -1);
    for (int k = 0; k < 5; k++) check("pin_frame_b", {24'b0, rx_bytes[k]}, {24'b0, pin_b[k]});

    // overrun with x_pos changing mid-frame
    x_pos = 10'h155; y_pos = 10'h2AA; buttons = 3'b011;
    run_frame(48, 8'h81, -1, 5);
    check("pin_overrun_tail", {24'b0, rx_bytes[5]}, 32'h00);
    check("pin_led_overrun", {30'b0, led}, 32'd1);

    // reset mid-frame, then a normal frame
    run_frame(40, 8'h82, 20, -1);
    x_pos = 10'h3FF; y_pos = 10'h001; buttons = 3'b110;
    run_frame(40, 8'h82, -1, -1);
    check("pin_led_after_rst", {30'b0, led}, 32'd2);

    // randomized frames
    for (int n = 0; n < 14; n++) begin
      int kind;
      int nb;
      int ra;
      x_pos = 10'($urandom_range(0, 1023));
      y_pos = 10'($urandom_range(0, 1023));
      buttons = 3'($urandom_range(0, 7));
      kind = $urandom_range(0, 3);
      nb = 40;
      ra = -1;
      if (kind == 1) nb = $urandom_range(0, 39);
      if (kind == 2) nb = $urandom_range(41, 48);
      if (kind == 3) ra = $urandom_range(0, 39);
      run_frame(nb, 8'($urandom_range(0, 255)), ra, $urandom_range(0, 39));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
